// File: rtl/frame_seq_if.sv
// Sync-strobe, configuration and status bundle for frame_sequencer.
// Strobes are single-cycle pulses with no backpressure; status outputs are valid every cycle.
interface frame_seq_if #(
    parameter int LINE_W = 12,
    parameter int KERN_W = 10
);
    logic              enable;
    logic              fs;
    logic              fe;
    logic              ls;
    logic              le;
    logic              img;
    logic [LINE_W-1:0] cfg_lines;
    logic [KERN_W-1:0] cfg_kernels;
    logic              err_clr;
    logic              frame_valid;
    logic              line_valid;
    logic              pixel_valid;
    logic [LINE_W-1:0] line_cnt;
    logic [KERN_W-1:0] kernel_cnt;
    logic              frame_done;
    logic [15:0]       frame_cnt;
    logic              err_seq;
    logic              err_size;
    logic              err_tmo;
    logic [1:0]        state_dbg;

    modport master (
        output enable, fs, fe, ls, le, img, cfg_lines, cfg_kernels, err_clr,
        input  frame_valid, line_valid, pixel_valid, line_cnt, kernel_cnt,
               frame_done, frame_cnt, err_seq, err_size, err_tmo, state_dbg
    );

    modport slave (
        input  enable, fs, fe, ls, le, img, cfg_lines, cfg_kernels, err_clr,
        output frame_valid, line_valid, pixel_valid, line_cnt, kernel_cnt,
               frame_done, frame_cnt, err_seq, err_size, err_tmo, state_dbg
    );
endinterface

// File: rtl/frame_sequencer.sv
// Tracks frame/line/kernel sync strobes against a latched frame geometry and
// reports completed frames plus sticky protocol, size and inactivity errors.
module frame_sequencer #(
    parameter int LINE_W = 12,
    parameter int KERN_W = 10,
    parameter int WDOG_W = 16
) (
    input  logic        pclock,
    input  logic        reset,
    frame_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FS = 2'd1, FRAME = 2'd2, LINE = 2'd3} state_t;

    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    state_t            state, state_n;
    logic [LINE_W-1:0] line_cnt, line_n, cfg_l, cfg_l_n;
    logic [KERN_W-1:0] kernel_cnt, kern_n, cfg_k, cfg_k_n;
    logic [WDOG_W-1:0] wdog, wdog_n;
    logic [15:0]       frame_cnt, frame_cnt_n;
    logic              frame_bad, bad_n;
    logic              frame_done, done_n;
    logic              err_seq, err_size, err_tmo;
    logic              seq_set, size_set, tmo_set;
    logic              any_strobe, multi;
    logic              kern_ok, lines_ok;

    assign any_strobe = bus.fs | bus.fe | bus.ls | bus.le | bus.img;
    assign multi      = $countones({bus.fs, bus.fe, bus.ls, bus.le, bus.img}) > 1;
    assign kern_ok    = (kernel_cnt == cfg_k);
    assign lines_ok   = ((line_cnt + LINE_W'(1)) == cfg_l);

    always_comb begin
        state_n     = state;
        line_n      = line_cnt;
        kern_n      = kernel_cnt;
        cfg_l_n     = cfg_l;
        cfg_k_n     = cfg_k;
        wdog_n      = wdog;
        frame_cnt_n = frame_cnt;
        bad_n       = frame_bad;
        done_n      = 1'b0;
        seq_set     = 1'b0;
        size_set    = 1'b0;
        tmo_set     = 1'b0;
        case (state)
            IDLE: begin
                wdog_n = '0;
                if (bus.enable) state_n = WAIT_FS;
            end
            WAIT_FS: begin
                wdog_n = '0;
                if (!bus.enable) begin
                    state_n = IDLE;
                end else if (multi) begin
                    seq_set = 1'b1;
                end else if (bus.fs) begin
                    state_n = LINE;
                    line_n  = '0;
                    kern_n  = '0;
                    cfg_l_n = bus.cfg_lines;
                    cfg_k_n = bus.cfg_kernels;
                    bad_n   = 1'b0;
                end
            end
            default: begin
                wdog_n = '0;
                if (multi) begin
                    seq_set = 1'b1;
                end else if (!any_strobe) begin
                    if (wdog == WDOG_LAST) begin
                        tmo_set = 1'b1;
                        state_n = bus.enable ? WAIT_FS : IDLE;
                    end else begin
                        wdog_n = wdog + WDOG_W'(1);
                    end
                end else if (bus.fs) begin
                    // A premature fs abandons the current frame and starts a fresh one.
                    seq_set = 1'b1;
                    state_n = LINE;
                    line_n  = '0;
                    kern_n  = '0;
                    cfg_l_n = bus.cfg_lines;
                    cfg_k_n = bus.cfg_kernels;
                    bad_n   = 1'b0;
                end else if (state == LINE) begin
                    if (bus.img) begin
                        if (kernel_cnt != '1) kern_n = kernel_cnt + KERN_W'(1);
                    end else if (bus.le) begin
                        state_n = FRAME;
                        if (!kern_ok) begin
                            size_set = 1'b1;
                            bad_n    = 1'b1;
                        end
                    end else if (bus.fe) begin
                        frame_cnt_n = frame_cnt + 16'd1;
                        state_n     = bus.enable ? WAIT_FS : IDLE;
                        if (!kern_ok || !lines_ok) size_set = 1'b1;
                        else done_n = !frame_bad;
                    end else begin
                        seq_set = 1'b1;
                        kern_n  = '0;
                        if (line_cnt != '1) line_n = line_cnt + LINE_W'(1);
                    end
                end else begin
                    if (bus.ls) begin
                        state_n = LINE;
                        kern_n  = '0;
                        if (line_cnt != '1) line_n = line_cnt + LINE_W'(1);
                    end else begin
                        seq_set = 1'b1;
                        if (bus.fe) state_n = WAIT_FS;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge pclock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            line_cnt   <= '0;
            kernel_cnt <= '0;
            cfg_l      <= '0;
            cfg_k      <= '0;
            wdog       <= '0;
            frame_cnt  <= '0;
            frame_bad  <= 1'b0;
            frame_done <= 1'b0;
            err_seq    <= 1'b0;
            err_size   <= 1'b0;
            err_tmo    <= 1'b0;
        end else begin
            state      <= state_n;
            line_cnt   <= line_n;
            kernel_cnt <= kern_n;
            cfg_l      <= cfg_l_n;
            cfg_k      <= cfg_k_n;
            wdog       <= wdog_n;
            frame_cnt  <= frame_cnt_n;
            frame_bad  <= bad_n;
            frame_done <= done_n;
            // A new error in the clearing cycle keeps its flag set.
            err_seq    <= (err_seq  & ~bus.err_clr) | seq_set;
            err_size   <= (err_size & ~bus.err_clr) | size_set;
            err_tmo    <= (err_tmo  & ~bus.err_clr) | tmo_set;
        end
    end

    assign bus.frame_valid = (state == FRAME) || (state == LINE);
    assign bus.line_valid  = (state == LINE);
    assign bus.pixel_valid = (state == LINE) && bus.img && !multi;
    assign bus.line_cnt    = line_cnt;
    assign bus.kernel_cnt  = kernel_cnt;
    assign bus.frame_done  = frame_done;
    assign bus.frame_cnt   = frame_cnt;
    assign bus.err_seq     = err_seq;
    assign bus.err_size    = err_size;
    assign bus.err_tmo     = err_tmo;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: scoreboard queues for pixel_valid and
// frame_done events plus direct status checks between stimulus steps.
module tb_frame_sequencer;
    localparam int LW = 12;
    localparam int KW = 10;

    localparam logic [4:0] S_FS  = 5'b10000;
    localparam logic [4:0] S_FE  = 5'b01000;
    localparam logic [4:0] S_LS  = 5'b00100;
    localparam logic [4:0] S_LE  = 5'b00010;
    localparam logic [4:0] S_IMG = 5'b00001;

    logic pclock = 1'b0;
    logic reset  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [KW-1:0] pix_q[$];
    logic [15:0]   done_q[$];

    frame_seq_if #(.LINE_W(LW), .KERN_W(KW)) bus ();

    frame_sequencer #(.LINE_W(LW), .KERN_W(KW), .WDOG_W(4)) dut (
        .pclock (pclock),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 pclock = ~pclock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Each driver task starts and ends just after a rising edge.
    task automatic drive(input logic [4:0] s);
        {bus.fs, bus.fe, bus.ls, bus.le, bus.img} = s;
        @(posedge pclock); #1;
        {bus.fs, bus.fe, bus.ls, bus.le, bus.img} = 5'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclock);
        #1;
    endtask

    task automatic send_line(input int k);
        for (int i = 0; i < k; i++) begin
            pix_q.push_back(KW'(i));
            drive(S_IMG);
        end
    endtask

    task automatic clear_err();
        bus.err_clr = 1'b1;
        idle(1);
        bus.err_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},    32'(bus.state_dbg), 0);
        check({tag, "_fvalid"},   32'(bus.frame_valid), 0);
        check({tag, "_lvalid"},   32'(bus.line_valid), 0);
        check({tag, "_pvalid"},   32'(bus.pixel_valid), 0);
        check({tag, "_line"},     32'(bus.line_cnt), 0);
        check({tag, "_kern"},     32'(bus.kernel_cnt), 0);
        check({tag, "_done"},     32'(bus.frame_done), 0);
        check({tag, "_fcnt"},     32'(bus.frame_cnt), 0);
        check({tag, "_errs"},     32'({bus.err_seq, bus.err_size, bus.err_tmo}), 0);
    endtask

    // Monitor: every presented pixel/frame_done must match the head of its queue.
    always @(negedge pclock) begin
        if (reset) begin
            if (bus.pixel_valid) begin
                if (pix_q.size() == 0) begin
                    check("pix_unexpected", 1, 0);
                end else begin
                    check("pix_kernel_idx", 32'(bus.kernel_cnt), 32'(pix_q.pop_front()));
                end
            end
            if (bus.frame_done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    check("done_frame_cnt", 32'(bus.frame_cnt), 32'(done_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.enable      = 1'b0;
        {bus.fs, bus.fe, bus.ls, bus.le, bus.img} = 5'b0;
        bus.cfg_lines   = LW'(3);
        bus.cfg_kernels = KW'(4);
        bus.err_clr     = 1'b0;
        #22;
        check_all_zero("reset");
        @(negedge pclock);
        reset = 1'b1;
        idle(1);

        // fs while still IDLE is ignored
        drive(S_FS);
        check("idle_fs_state", 32'(bus.state_dbg), 0);

        // Clean 3x4 frame
        bus.enable = 1'b1;
        idle(1);
        check("arm_state", 32'(bus.state_dbg), 1);
        drive(S_FS);
        check("fs_lvalid", 32'(bus.line_valid), 1);
        send_line(4);
        drive(S_LE);
        check("le_state_frame", 32'(bus.state_dbg), 2);
        check("le_fvalid", 32'(bus.frame_valid), 1);
        drive(S_LS);
        send_line(4);
        drive(S_LE);
        drive(S_LS);
        check("line2_idx", 32'(bus.line_cnt), 2);
        send_line(4);
        check("line2_kern", 32'(bus.kernel_cnt), 4);
        done_q.push_back(16'd1);
        drive(S_FE);
        check("t1_fcnt", 32'(bus.frame_cnt), 1);
        check("t1_errs", 32'({bus.err_seq, bus.err_size, bus.err_tmo}), 0);
        check("t1_state", 32'(bus.state_dbg), 1);

        // Short line 1: size error, no frame_done, still counted
        drive(S_FS);
        send_line(4);
        drive(S_LE);
        drive(S_LS);
        send_line(3);
        drive(S_LE);
        check("short_err_size", 32'(bus.err_size), 1);
        drive(S_LS);
        send_line(4);
        drive(S_FE);
        check("t2_fcnt", 32'(bus.frame_cnt), 2);
        clear_err();
        check("t2_clr", 32'(bus.err_size), 0);

        // fs and img together in WAIT_FS
        drive(S_FS | S_IMG);
        check("multi_err_seq", 32'(bus.err_seq), 1);
        check("multi_state", 32'(bus.state_dbg), 1);
        clear_err();

        // Watchdog with WDOG_W=4: fires on the 15th silent cycle
        drive(S_FS);
        idle(14);
        check("wdog_pre", 32'(bus.err_tmo), 0);
        idle(1);
        check("wdog_tmo", 32'(bus.err_tmo), 1);
        check("wdog_fvalid", 32'(bus.frame_valid), 0);
        clear_err();
        check("wdog_clr", 32'(bus.err_tmo), 0);

        // Order errors inside a frame, then a valid frame after a restart
        drive(S_FS);
        send_line(1);
        drive(S_LS | S_LE);
        check("line_multi_seq", 32'(bus.err_seq), 1);
        check("line_multi_kern", 32'(bus.kernel_cnt), 1);
        drive(S_FS);
        check("restart_kern", 32'(bus.kernel_cnt), 0);
        check("restart_state", 32'(bus.state_dbg), 3);
        clear_err();
        send_line(4);
        drive(S_LE);
        drive(S_IMG);
        check("frame_img_seq", 32'(bus.err_seq), 1);
        check("frame_img_state", 32'(bus.state_dbg), 2);
        clear_err();
        drive(S_LS);
        send_line(4);
        drive(S_LE);
        drive(S_LS);
        send_line(4);
        done_q.push_back(16'd3);
        drive(S_FE);
        check("t5_fcnt", 32'(bus.frame_cnt), 3);
        check("t5_errs", 32'({bus.err_seq, bus.err_size, bus.err_tmo}), 0);

        // enable drops mid-frame: frame completes, then IDLE
        drive(S_FS);
        bus.enable = 1'b0;
        send_line(4);
        drive(S_LE);
        drive(S_LS);
        send_line(4);
        drive(S_LE);
        drive(S_LS);
        send_line(4);
        done_q.push_back(16'd4);
        drive(S_FE);
        check("dis_state", 32'(bus.state_dbg), 0);
        check("dis_fcnt", 32'(bus.frame_cnt), 4);
        drive(S_FS);
        check("dis_fs_ignored", 32'(bus.frame_valid), 0);

        // Asynchronous reset mid-line
        bus.enable = 1'b1;
        idle(1);
        drive(S_FS);
        send_line(2);
        check("pre_rst_kern", 32'(bus.kernel_cnt), 2);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        idle(2);
        @(negedge pclock);
        reset = 1'b1;
        idle(3);
        check("post_rst_fcnt", 32'(bus.frame_cnt), 0);
        check("pix_q_empty", 32'(pix_q.size()), 0);
        check("done_q_empty", 32'(done_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
